// File: rtl/stream_wrr_arb_if.sv
// Input/output stream bundle of the weighted round-robin arbiter: NumInp valid/ready inputs, one granted output.
interface stream_wrr_arb_if #(
  parameter int NumInp    = 4,
  parameter int DataWidth = 16,
  parameter int IdxW      = (NumInp > 1) ? $clog2(NumInp) : 1
);
  logic [NumInp*DataWidth-1:0] data_i;
  logic [NumInp-1:0]           valid_i;
  logic [NumInp-1:0]           ready_o;
  logic [DataWidth-1:0]        data_o;
  logic [IdxW-1:0]             idx_o;
  logic                        valid_o;
  logic                        ready_i;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, idx_o, valid_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, idx_o, valid_o
  );
endinterface

// File: rtl/stream_wrr_arb.sv
// Weighted round-robin stream arbiter, zero-latency mux; grant locked while valid_o waits on ready_i.
// Optional STREAM_WRR_ARB_STARVE_EN adds per-input saturating wait counters driving starve_o.
module stream_wrr_arb #(
  parameter  int NumInp      = 4,
  parameter  int DataWidth   = 16,
  parameter  int WeightWidth = 4,
  parameter  int StarveThr   = 64,
  localparam int IdxW        = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [NumInp*WeightWidth-1:0] weight_i,
`ifdef STREAM_WRR_ARB_STARVE_EN
  output logic [NumInp-1:0]             starve_o,
`endif
  stream_wrr_arb_if.slave               bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]             st;
  logic [IdxW-1:0]        cur, ptr, winner, sel;
  logic [WeightWidth-1:0] quota, w_win, q_load;
  logic                   found, keep, grant, hs;

  function automatic logic [IdxW-1:0] rot_idx(input logic [IdxW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumInp) s = s - NumInp;
    return IdxW'(s);
  endfunction

  // Scan from the far end so the earliest input in rotation order is written last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NumInp - 1; i >= 0; i--) begin
      if (bus.valid_i[rot_idx(ptr, i)]) begin
        winner = rot_idx(ptr, i);
        found  = 1'b1;
      end
    end
  end

  // rst_n is active-high in this codebase: a grant only exists while it is low.
  assign keep   = (st == BURST) && bus.valid_i[cur];
  assign sel    = keep ? cur : winner;
  assign grant  = !rst_n && !flush_i && (keep || found);
  assign hs     = grant && bus.ready_i;
  assign w_win  = weight_i[winner*WeightWidth +: WeightWidth];
  assign q_load = (w_win == '0) ? WeightWidth'(1) : w_win;

  always_comb begin
    bus.valid_o = grant;
    bus.idx_o   = grant ? sel : '0;
    bus.data_o  = grant ? bus.data_i[sel*DataWidth +: DataWidth] : '0;
    bus.ready_o = '0;
    if (grant) bus.ready_o[sel] = bus.ready_i;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      st    <= IDLE;
      cur   <= '0;
      ptr   <= '0;
      quota <= '0;
    end else if (flush_i) begin
      st    <= IDLE;
      cur   <= '0;
      ptr   <= '0;
      quota <= '0;
    end else if (grant && !keep) begin
      cur <= winner;
      ptr <= (winner == IdxW'(NumInp - 1)) ? '0 : winner + 1'b1;
      if (hs) begin
        quota <= q_load - WeightWidth'(1);
        st    <= (q_load == WeightWidth'(1)) ? IDLE : BURST;
      end else begin
        quota <= q_load;
        st    <= BURST;
      end
    end else if (keep) begin
      if (hs) begin
        quota <= quota - WeightWidth'(1);
        if (quota == WeightWidth'(1)) st <= IDLE;
      end
    end else begin
      st <= IDLE;
    end
  end

`ifdef STREAM_WRR_ARB_STARVE_EN
  logic [15:0] wait_cnt [NumInp];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int k = 0; k < NumInp; k++) wait_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NumInp; k++) begin
        if (flush_i || (bus.valid_i[k] && bus.ready_o[k]))
          wait_cnt[k] <= '0;
        else if (bus.valid_i[k] && !bus.ready_o[k] && (wait_cnt[k] != 16'hFFFF))
          wait_cnt[k] <= wait_cnt[k] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumInp; k++) starve_o[k] = (wait_cnt[k] >= 16'(StarveThr));
  end
`endif

  for (genvar k = 0; k < NumInp; k++) begin : g_in_hold
    a_valid_held: assert property (@(posedge clk) disable iff (rst_n)
      (bus.valid_i[k] && !bus.ready_o[k]) |=> bus.valid_i[k]);
  end

  a_out_locked: assert property (@(posedge clk) disable iff (rst_n)
    (bus.valid_o && !bus.ready_i && !flush_i) |=> (flush_i || (bus.valid_o && $stable(bus.idx_o))));

endmodule

// File: tb/tb_stream_wrr_arb.sv
// Bench for stream_wrr_arb: directed rotation/weight/lock/flush/reset scenarios plus a randomized model check.
module tb_stream_wrr_arb;
  localparam int NI = 4;
  localparam int DW = 16;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic [NI*WW-1:0] weight_i;
`ifdef STREAM_WRR_ARB_STARVE_EN
  logic [NI-1:0]   starve_o;
`endif

  logic [NI-1:0]   vin;
  logic [DW-1:0]   din [NI];
  logic            rdy;
  int              n_cmp = 0;
  int              n_bad = 0;

  stream_wrr_arb_if #(.NumInp(NI), .DataWidth(DW), .IdxW(2)) bus ();

  stream_wrr_arb #(.NumInp(NI), .DataWidth(DW), .WeightWidth(WW), .StarveThr(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .weight_i (weight_i),
`ifdef STREAM_WRR_ARB_STARVE_EN
    .starve_o (starve_o),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply();
    bus.valid_i = vin;
    bus.ready_i = rdy;
    for (int k = 0; k < NI; k++) bus.data_i[k*DW +: DW] = din[k];
  endtask

  function automatic logic [3:0] onehot(input int id);
    return 4'(1 << id);
  endfunction

  // Expected {valid_o, idx_o, data_o, ready_o} for a grant to input id.
  function automatic logic [22:0] pack(input int id, input logic [3:0] r);
    return {1'b1, 2'(id), din[id], r};
  endfunction

  function automatic logic [22:0] got();
    return {bus.valid_o, bus.idx_o, bus.data_o, bus.ready_o};
  endfunction

  task automatic do_reset();
    rst_n   = 1'b1;
    flush_i = 1'b0;
    vin     = '0;
    rdy     = 1'b0;
    for (int k = 0; k < NI; k++) din[k] = '0;
    apply();
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    rst_n = 1'b1; flush_i = 1'b0; weight_i = 16'h1111; vin = 4'hF; rdy = 1'b1;
    for (int k = 0; k < NI; k++) din[k] = 16'(16'h1000 + k);
    apply();
    smp();
    n_cmp++;
    if (got() !== 23'h0) begin
      n_bad++; $display("FAIL reset_outputs got %h want %h", got(), 23'h0);
    end
    tick();
    rst_n = 1'b0;
    smp();
    e = pack(0, onehot(0));
    n_cmp++;
    if (got() !== e) begin
      n_bad++; $display("FAIL reset_first_grant got %h want %h", got(), e);
    end
  endtask

  task automatic test_round_robin();
    logic [22:0] e;
    do_reset();
    weight_i = 16'h1111; vin = 4'hF; rdy = 1'b1;
    for (int k = 0; k < NI; k++) din[k] = 16'(16'h2000 + k);
    apply();
    for (int c = 0; c < 8; c++) begin
      smp();
      e = pack(c % NI, onehot(c % NI));
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL round_robin c=%0d got %h want %h", c, got(), e);
      end
      tick();
    end
  endtask

  task automatic test_weighted();
    int exp_id [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic [22:0] e;
    do_reset();
    weight_i = 16'h1103; vin = 4'b0011; rdy = 1'b1;
    din[0] = 16'h0A0A; din[1] = 16'h1B1B;
    apply();
    for (int c = 0; c < 8; c++) begin
      smp();
      e = pack(exp_id[c], onehot(exp_id[c]));
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL weighted c=%0d got %h want %h", c, got(), e);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    logic [22:0] e;
    do_reset();
    weight_i = 16'h1111; vin = 4'b0100; rdy = 1'b0;
    din[2] = 16'hBEEF; din[0] = 16'h1234;
    apply();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) vin[0] = 1'b1;
      if (c == 3) rdy = 1'b1;
      if (c == 4) vin[2] = 1'b0;
      apply();
      smp();
      e = (c < 4) ? pack(2, rdy ? onehot(2) : 4'b0) : pack(0, onehot(0));
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL lock c=%0d got %h want %h", c, got(), e);
      end
      tick();
    end
  endtask

  task automatic test_early_end();
    logic [22:0] e;
    do_reset();
    weight_i = 16'h1141; vin = 4'b1010; rdy = 1'b1;
    din[1] = 16'h1111; din[3] = 16'h3333;
    apply();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) vin[1] = 1'b0;
      apply();
      smp();
      e = (c < 2) ? pack(1, onehot(1)) : pack(3, onehot(3));
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL early_end c=%0d got %h want %h", c, got(), e);
      end
      tick();
    end
  endtask

  task automatic test_flush_reset();
    int exp_id [7] = '{0, 2, 2, -1, 0, 2, 2};
    logic [22:0] e;
    do_reset();
    weight_i = 16'h1411; vin = 4'b0101; rdy = 1'b1;
    din[0] = 16'hA0A0; din[2] = 16'hC2C2;
    apply();
    for (int c = 0; c < 7; c++) begin
      flush_i = (c == 3);
      smp();
      e = (exp_id[c] < 0) ? 23'h0 : pack(exp_id[c], onehot(exp_id[c]));
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL flush c=%0d got %h want %h", c, got(), e);
      end
      tick();
    end
    rst_n = 1'b1;
    smp();
    n_cmp++;
    if (got() !== 23'h0) begin
      n_bad++; $display("FAIL reset_mid_burst got %h want %h", got(), 23'h0);
    end
    tick();
    tick();
    rst_n = 1'b0;
    smp();
    e = pack(0, onehot(0));
    n_cmp++;
    if (got() !== e) begin
      n_bad++; $display("FAIL reset_restart got %h want %h", got(), e);
    end
  endtask

`ifdef STREAM_WRR_ARB_STARVE_EN
  task automatic test_starve();
    logic [3:0] es;
    do_reset();
    weight_i = 16'h1111; vin = 4'b1001; rdy = 1'b0;
    din[0] = 16'h0F0F; din[3] = 16'h3F3F;
    apply();
    for (int c = 0; c < 13; c++) begin
      if (c == 10) rdy = 1'b1;
      if (c == 11) vin[0] = 1'b0;
      if (c == 12) vin[3] = 1'b0;
      apply();
      smp();
      es = (c < 8) ? 4'b0000 : (c < 11) ? 4'b1001 : (c == 11) ? 4'b1000 : 4'b0000;
      if (c == 7 || c == 8 || c == 10 || c == 11 || c == 12) begin
        n_cmp++;
        if (starve_o !== es) begin
          n_bad++; $display("FAIL starve c=%0d got %b want %b", c, starve_o, es);
        end
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    int owner, rot, left, e, w;
    bit cont, hs;
    logic [NI-1:0] acc;
    logic [22:0] ex;
    do_reset();
    owner = -1; rot = 0; left = 0; acc = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 16 == 0)
        for (int k = 0; k < NI; k++) weight_i[k*WW +: WW] = 4'($urandom_range(0, 5));
      for (int k = 0; k < NI; k++) begin
        if (!vin[k] || acc[k]) begin
          vin[k] = ($urandom_range(0, 2) != 0);
          din[k] = 16'($urandom);
        end
      end
      rdy     = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 31) == 0);
      apply();
      // Current holder keeps the grant while it stays valid; otherwise first valid from the rotation start.
      cont = (owner >= 0) && vin[owner];
      e = -1;
      if (!flush_i) begin
        if (cont) e = owner;
        else
          for (int i = 0; i < NI; i++)
            if (e < 0 && vin[(rot + i) % NI]) e = (rot + i) % NI;
      end
      ex  = (e >= 0) ? pack(e, rdy ? onehot(e) : 4'b0) : 23'h0;
      hs  = (e >= 0) && rdy;
      acc = hs ? onehot(e) : '0;
      smp();
      n_cmp++;
      if (got() !== ex) begin
        n_bad++; $display("FAIL random c=%0d got %h want %h", c, got(), ex);
      end
      if (flush_i) begin
        owner = -1; rot = 0;
      end else if (e < 0) begin
        owner = -1;
      end else begin
        if (!cont) begin
          owner = e;
          rot   = (e + 1) % NI;
          w     = int'(weight_i[e*WW +: WW]);
          left  = (w == 0) ? 1 : w;
        end
        if (hs) begin
          left--;
          if (left == 0) owner = -1;
        end
      end
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_lock();
    test_early_end();
    test_flush_reset();
`ifdef STREAM_WRR_ARB_STARVE_EN
    test_starve();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
